// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges ALU and long-latency results onto the single register-file
// write port, buffers long-latency results in a FIFO and tracks pending destinations.
module wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     AluValid,
  input  logic [AW-1:0]            AluRd,
  input  logic [DW-1:0]            AluData,
  input  logic                     LuValid,
  output logic                     LuReady,
  input  logic [AW-1:0]            LuRd,
  input  logic [DW-1:0]            LuData,
  input  logic                     IssueValid,
  input  logic [AW-1:0]            IssueRd,
  input  logic [AW-1:0]            QRs1,
  input  logic [AW-1:0]            QRs2,
  output logic                     Pend1,
  output logic                     Pend2,
  output logic [AW-1:0]            RD,
  output logic [DW-1:0]            WData,
  output logic                     RegWr,
  output logic [$clog2(DEPTH):0]   FifoCount
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;
  localparam int NREG = 1 << AW;

  // FIFO storage
  logic [AW-1:0] fifo_rd_mem   [DEPTH];
  logic [DW-1:0] fifo_data_mem [DEPTH];

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q,  count_d;
  logic [NREG-1:0] pend_q,   pend_d;
  logic            reg_wr_q, reg_wr_d;
  logic [AW-1:0]   rd_q,     rd_d;
  logic [DW-1:0]   wdata_q,  wdata_d;

  logic          lu_ready;
  logic          alu_sel;
  logic          fifo_sel;
  logic          push;
  logic [AW-1:0] head_rd;
  logic [DW-1:0] head_data;

  assign lu_ready  = (count_q < CW'(DEPTH));
  assign alu_sel   = AluValid && (AluRd != '0);
  assign head_rd   = fifo_rd_mem[rd_ptr_q];
  assign head_data = fifo_data_mem[rd_ptr_q];
  // An x0 ALU result forfeits its slot, so the FIFO head may use it.
  assign fifo_sel  = !alu_sel && (count_q != '0) && (head_rd != '0);
  // x0 long-latency results complete the handshake but are never stored.
  assign push      = LuValid && lu_ready && (LuRd != '0);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    reg_wr_d = 1'b0;
    rd_d     = rd_q;
    wdata_d  = wdata_q;
    pend_d   = pend_q;

    if (push)     wr_ptr_d = wr_ptr_q + PW'(1);
    if (fifo_sel) rd_ptr_d = rd_ptr_q + PW'(1);

    case ({push, fifo_sel})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (alu_sel) begin
      reg_wr_d = 1'b1;
      rd_d     = AluRd;
      wdata_d  = AluData;
    end else if (fifo_sel) begin
      reg_wr_d = 1'b1;
      rd_d     = head_rd;
      wdata_d  = head_data;
    end

    // Clear before set so a same-cycle reissue keeps the register pending.
    if (fifo_sel)                       pend_d[head_rd] = 1'b0;
    if (IssueValid && (IssueRd != '0))  pend_d[IssueRd] = 1'b1;
    pend_d[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      pend_q   <= '0;
      reg_wr_q <= 1'b0;
      rd_q     <= '0;
      wdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
      reg_wr_q <= reg_wr_d;
      rd_q     <= rd_d;
      wdata_q  <= wdata_d;
    end
  end

  // NOTE: FIFO storage is not reset; entries are only read while count_q covers them.
  always_ff @(posedge Clk) begin
    if (push) begin
      fifo_rd_mem[wr_ptr_q]   <= LuRd;
      fifo_data_mem[wr_ptr_q] <= LuData;
    end
  end

  assign LuReady   = lu_ready;
  assign Pend1     = pend_q[QRs1];
  assign Pend2     = pend_q[QRs2];
  assign RegWr     = reg_wr_q;
  assign RD        = rd_q;
  assign WData     = wdata_q;
  assign FifoCount = count_q;

endmodule
